// File: rtl/div_sched.sv
`default_nettype none
// ============================================================================
// Module      : div_sched
// Description : Two-port round-robin scheduler around a shared restoring
//               divider. Accepts one operation at a time, runs one restoring
//               iteration per clock, applies sign correction and returns
//               quotient/remainder with the owner ID over valid/ready.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               req{0,1}_valid/ready  - request handshake per requester
//               req{0,1}_dividend/divisor/signed - request operands
//               rsp_valid/rsp_ready   - response handshake
//               rsp_id, rsp_quotient, rsp_remainder, rsp_dbz - response data
//               busy                  - controller not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module div_sched #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_dividend,
    input  logic [WIDTH-1:0] req0_divisor,
    input  logic             req0_signed,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_dividend,
    input  logic [WIDTH-1:0] req1_divisor,
    input  logic             req1_signed,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_dbz,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic               owner_q, owner_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    // Partial remainder (upper half) and quotient/dividend (lower half).
    // The upper half always holds a value below the divisor between
    // iterations, so WIDTH bits suffice; the extra bit lives only in the
    // shifted/trial values below.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    // Arbitration and operand selection
    logic               grant1;
    logic               accept;
    logic [WIDTH-1:0]   sel_dvd;
    logic [WIDTH-1:0]   sel_dvs;
    logic               sel_sgn;
    logic [WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]   dvs_mag;
    logic               div_zero;

    // One restoring step
    logic [2*WIDTH:0]   shifted;
    logic [WIDTH:0]     trial;

    always_comb begin
        // Port 1 wins when it is alone, or when both are valid and the
        // pointer favours it.
        grant1   = req1_valid && (!req0_valid || rr_ptr_q);
        accept   = (state_q == S_IDLE) && (req0_valid || req1_valid);
        sel_dvd  = grant1 ? req1_dividend : req0_dividend;
        sel_dvs  = grant1 ? req1_divisor  : req0_divisor;
        sel_sgn  = grant1 ? req1_signed   : req0_signed;
        dvd_mag  = (sel_sgn && sel_dvd[WIDTH-1]) ? -sel_dvd : sel_dvd;
        dvs_mag  = (sel_sgn && sel_dvs[WIDTH-1]) ? -sel_dvs : sel_dvs;
        div_zero = (sel_dvs == '0);
        shifted  = {acc_q, 1'b0};
        trial    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_q};
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = div_zero ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == LAST_CNT) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready    = (state_q == S_IDLE) && req0_valid && !grant1;
        req1_ready    = (state_q == S_IDLE) && grant1;
        rsp_valid     = (state_q == S_DONE);
        busy          = (state_q != S_IDLE);
        rsp_id        = owner_q;
        rsp_quotient  = quo_q;
        rsp_remainder = rem_q;
        rsp_dbz       = dbz_q;
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        divisor_d = divisor_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    owner_d   = grant1;
                    rr_ptr_d  = !grant1;
                    divisor_d = dvs_mag;
                    acc_d     = {{WIDTH{1'b0}}, dvd_mag};
                    cnt_d     = '0;
                    neg_quo_d = sel_sgn && (sel_dvd[WIDTH-1] ^ sel_dvs[WIDTH-1]);
                    neg_rem_d = sel_sgn && sel_dvd[WIDTH-1];
                    if (div_zero) begin
                        // Remainder reports the dividend as presented, not
                        // its magnitude.
                        quo_d = '1;
                        rem_d = sel_dvd;
                        dbz_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                // A negative trial means the divisor did not fit: keep the
                // shifted value (quotient bit 0). Otherwise commit the
                // difference and set the quotient bit. When the trial is
                // negative the shifted-out top bit is always zero.
                if (trial[WIDTH]) begin
                    acc_d = shifted[2*WIDTH-1:0];
                end else begin
                    acc_d = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_FIX: begin
                quo_d = neg_quo_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                rem_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                dbz_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q  <= 1'b0;
            owner_q   <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divisor_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            divisor_q <= divisor_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_sched
// Description : Directed self-checking bench for div_sched (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_signed;
    logic [31:0] req0_dividend, req0_divisor;
    logic        req1_valid, req1_ready, req1_signed;
    logic [31:0] req1_dividend, req1_divisor;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_dbz, busy;
    logic [31:0] rsp_quotient, rsp_remainder;

    int total;
    int bad;

    always #5 clk = ~clk;

    div_sched #(.WIDTH(32), .CNT_W(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_dividend (req0_dividend),
        .req0_divisor  (req0_divisor),
        .req0_signed   (req0_signed),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_dividend (req1_dividend),
        .req1_divisor  (req1_divisor),
        .req1_signed   (req1_signed),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_dbz       (rsp_dbz),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int port, input logic v, input logic [31:0] dvd,
                            input logic [31:0] dvs, input logic sgn);
        if (port == 0) begin
            req0_valid = v; req0_dividend = dvd; req0_divisor = dvs; req0_signed = sgn;
        end else begin
            req1_valid = v; req1_dividend = dvd; req1_divisor = dvs; req1_signed = sgn;
        end
    endtask

    // Called just after a falling edge. Returns just after the falling edge
    // of the first cycle following the accept, with valid dropped.
    task automatic issue(input int port, input logic [31:0] dvd,
                         input logic [31:0] dvs, input logic sgn);
        int n;
        n = 0;
        set_port(port, 1'b1, dvd, dvs, sgn);
        #1;
        while (!(port == 0 ? req0_ready : req1_ready) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("accept_timeout", 32'(n < 100), 32'd1);
        @(posedge clk);
        @(negedge clk);
        set_port(port, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    // Counts cycles after the accept cycle until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int grants;
        int n;
        logic prev;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        rsp_ready = 1'b0;
        set_port(0, 1'b0, 32'd0, 32'd0, 1'b0);
        set_port(1, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_quo", rsp_quotient, 0);
        chk("rst_rem", rsp_remainder, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_dbz", rsp_dbz, 0);
        reset = 1'b0;
        @(negedge clk);

        // Unsigned, port 0, latency
        rsp_ready = 1'b1;
        issue(0, 32'd100, 32'd7, 1'b0);
        wait_rsp(lat);
        chk("u100_7_lat", lat, 34);
        chk("u100_7_quo", rsp_quotient, 14);
        chk("u100_7_rem", rsp_remainder, 2);
        chk("u100_7_id", rsp_id, 0);
        chk("u100_7_dbz", rsp_dbz, 0);

        // Signed, port 1
        issue(1, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_rsp(lat);
        chk("sm7_2_lat", lat, 34);
        chk("sm7_2_quo", rsp_quotient, 32'hFFFF_FFFD);
        chk("sm7_2_rem", rsp_remainder, 32'hFFFF_FFFF);
        chk("sm7_2_id", rsp_id, 1);
        issue(1, 32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_rsp(lat);
        chk("s7_m2_quo", rsp_quotient, 32'hFFFF_FFFD);
        chk("s7_m2_rem", rsp_remainder, 32'd1);
        issue(0, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1);
        wait_rsp(lat);
        chk("sm8_m3_quo", rsp_quotient, 32'd2);
        chk("sm8_m3_rem", rsp_remainder, 32'hFFFF_FFFE);
        issue(0, 32'hFFFF_FFFF, 32'h10, 1'b0);
        wait_rsp(lat);
        chk("umax_16_quo", rsp_quotient, 32'h0FFF_FFFF);
        chk("umax_16_rem", rsp_remainder, 32'hF);

        // Divide by zero and signed overflow
        issue(0, 32'h1234, 32'd0, 1'b0);
        wait_rsp(lat);
        chk("dbz_lat", lat, 1);
        chk("dbz_quo", rsp_quotient, 32'hFFFF_FFFF);
        chk("dbz_rem", rsp_remainder, 32'h1234);
        chk("dbz_flag", rsp_dbz, 1);
        issue(1, 32'hFFFF_FFF9, 32'd0, 1'b1);
        wait_rsp(lat);
        chk("sdbz_rem", rsp_remainder, 32'hFFFF_FFF9);
        chk("sdbz_id", rsp_id, 1);
        issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_rsp(lat);
        chk("ovf_quo", rsp_quotient, 32'h8000_0000);
        chk("ovf_rem", rsp_remainder, 32'd0);
        chk("ovf_dbz", rsp_dbz, 0);

        // Round robin with both ports valid continuously after reset
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_port(0, 1'b1, 32'hA0, 32'd0, 1'b0);
        set_port(1, 1'b1, 32'hB1, 32'd0, 1'b0);
        grants = 0;
        prev = 1'b0;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            #1;
            chk("rr_both_ready", 32'(req0_ready && req1_ready), 0);
            if (req0_ready || req1_ready) begin
                chk("rr_pulse", prev, 0);
                chk("rr_order", req1_ready, grants % 2);
                grants++;
            end
            prev = req0_ready || req1_ready;
            @(negedge clk);
        end
        chk("rr_grants", grants, 4);
        set_port(0, 1'b0, 32'd0, 32'd0, 1'b0);
        set_port(1, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);

        // Backpressure in DONE
        rsp_ready = 1'b0;
        issue(0, 32'd100, 32'd7, 1'b0);
        wait_rsp(lat);
        chk("bp_lat", lat, 34);
        set_port(0, 1'b1, 32'd50, 32'd5, 1'b0);
        set_port(1, 1'b1, 32'd9, 32'd3, 1'b0);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_quo", rsp_quotient, 14);
            chk("bp_rem", rsp_remainder, 2);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("hs_ready0", req0_ready, 0);
        chk("hs_ready1", req1_ready, 0);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("post_hs_valid", rsp_valid, 0);
        chk("post_hs_busy", busy, 0);
        chk("post_hs_ready1", req1_ready, 1);
        chk("post_hs_ready0", req0_ready, 0);
        @(posedge clk);
        @(negedge clk);
        set_port(0, 1'b0, 32'd0, 32'd0, 1'b0);
        set_port(1, 1'b0, 32'd0, 32'd0, 1'b0);
        rsp_ready = 1'b1;
        wait_rsp(lat);
        chk("bp2_lat", lat, 34);
        chk("bp2_quo", rsp_quotient, 3);
        chk("bp2_rem", rsp_remainder, 0);
        chk("bp2_id", rsp_id, 1);

        // Reset during CALC discards the operation
        set_port(0, 1'b1, 32'd1000, 32'd3, 1'b0);
        set_port(1, 1'b1, 32'd77, 32'd7, 1'b0);
        n = 0;
        #1;
        while (!req0_ready && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("mid_accept", 32'(n < 100), 1);
        @(posedge clk);
        repeat (15) @(negedge clk);
        #1;
        chk("mid_busy_calc", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_quo", rsp_quotient, 0);
        chk("mid_rst_id", rsp_id, 0);
        chk("mid_regrant0", req0_ready, 1);
        chk("mid_regrant1", req1_ready, 0);
        @(posedge clk);
        @(negedge clk);
        set_port(0, 1'b0, 32'd0, 32'd0, 1'b0);
        set_port(1, 1'b0, 32'd0, 32'd0, 1'b0);
        wait_rsp(lat);
        chk("rerun_lat", lat, 34);
        chk("rerun_quo", rsp_quotient, 333);
        chk("rerun_rem", rsp_remainder, 1);
        chk("rerun_id", rsp_id, 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
